// File: rtl/dsi_packet_tx.sv
// rtl/dsi_packet_tx.sv - two-lane DSI byte-level packet transmitter (optional EoTp via DSI_TX_EOTP_EN)
module dsi_packet_tx #(
  parameter int PREP_CYCLES = 8,
  parameter int TRAIL_BYTES = 1,
  parameter int EXIT_CYCLES = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pkt_start,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [1:0]  pkt_vc,
  input  logic [5:0]  pkt_dt,
  input  logic [15:0] pkt_wc,
  input  logic [15:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        hs_req,
  output logic [1:0]  lane_valid,
  output logic [15:0] lane_data,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_SYNC, S_HDR, S_PAY, S_CRC, S_TRAIL, S_EXIT
  } state_t;

`ifdef DSI_TX_EOTP_EN
  localparam logic [16:0] EOT_LEN = 17'd4;
`else
  localparam logic [16:0] EOT_LEN = 17'd0;
`endif

  state_t           state;
  logic [15:0]      cnt;
  logic             lat_long;
  logic [1:0]       lat_vc;
  logic [5:0]       lat_dt;
  logic [15:0]      lat_wc;
  logic [16:0]      pos;        // stream index of the byte lane0 sends at the next edge
  logic [15:0]      crc;
  logic [1:0][2:0]  trail_cnt;
  logic [1:0]       last_b7;

  logic [16:0]      pay_end, body_end, stream_end, pos_nx;
  logic             in_pay_cur, in_pay_nx, last_odd;
  logic [7:0]       pay_lo, pay_hi, ecc;
  logic [15:0]      crc_lo, crc_hi, crc_view;
  logic [16:0]      lane_pos [2];
  logic [16:0]      eot_off [2];
  logic [7:0]       lane_byte [2];
  logic [1:0]       lane_live, trail_live;

  function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408), one byte, LSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Stream geometry, payload CRC and per-lane byte selection for the current emission
  always_comb begin
    pay_end    = 17'd4 + {1'b0, lat_wc};
    body_end   = lat_long ? pay_end + 17'd2 : 17'd4;
    stream_end = body_end + EOT_LEN;
    pos_nx     = pos + 17'd2;
    in_pay_cur = lat_long && (pos >= 17'd4) && (pos < pay_end);
    in_pay_nx  = lat_long && (pos_nx >= 17'd4) && (pos_nx < pay_end);
    last_odd   = (pos + 17'd1) == pay_end;
    pay_lo     = pl_valid ? pl_data[7:0]  : 8'h00;
    pay_hi     = pl_valid ? pl_data[15:8] : 8'h00;
    crc_lo     = crc_byte(crc, pay_lo);
    crc_hi     = crc_byte(crc_lo, pay_hi);
    // On an odd final beat CRC_LS rides lane1 in the same cycle, so it must see the low byte only
    crc_view   = in_pay_cur ? (last_odd ? crc_lo : crc_hi) : crc;
    ecc        = hdr_ecc({lat_wc, lat_vc, lat_dt});
    for (int l = 0; l < 2; l++) begin
      lane_pos[l]   = pos + 17'(l);
      eot_off[l]    = lane_pos[l] - body_end;
      lane_live[l]  = lane_pos[l] < stream_end;
      trail_live[l] = !lane_live[l] && (trail_cnt[l] < 3'(TRAIL_BYTES));
      lane_byte[l]  = 8'h00;
      if (lane_pos[l] == 17'd0)                            lane_byte[l] = {lat_vc, lat_dt};
      else if (lane_pos[l] == 17'd1)                       lane_byte[l] = lat_wc[7:0];
      else if (lane_pos[l] == 17'd2)                       lane_byte[l] = lat_wc[15:8];
      else if (lane_pos[l] == 17'd3)                       lane_byte[l] = ecc;
      else if (lat_long && lane_pos[l] < pay_end)          lane_byte[l] = (l == 0) ? pay_lo : pay_hi;
      else if (lat_long && lane_pos[l] == pay_end)         lane_byte[l] = crc_view[7:0];
      else if (lat_long && lane_pos[l] == pay_end + 17'd1) lane_byte[l] = crc_view[15:8];
      else begin
`ifdef DSI_TX_EOTP_EN
        case (eot_off[l][1:0])
          2'd0:    lane_byte[l] = 8'h08;
          2'd1:    lane_byte[l] = 8'h0F;
          2'd2:    lane_byte[l] = 8'h0F;
          default: lane_byte[l] = 8'h01;
        endcase
`else
        lane_byte[l] = 8'h00;
`endif
      end
    end
  end

  // Packet sequencer with registered lane, handshake and status outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lat_long   <= 1'b0;
      lat_vc     <= '0;
      lat_dt     <= '0;
      lat_wc     <= '0;
      pos        <= '0;
      crc        <= 16'hFFFF;
      trail_cnt  <= '0;
      last_b7    <= '0;
      pkt_ready  <= 1'b0;
      pl_ready   <= 1'b0;
      hs_req     <= 1'b0;
      lane_valid <= '0;
      lane_data  <= '0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          pkt_ready <= 1'b1;
          if (pkt_start && pkt_ready) begin
            lat_long  <= pkt_long;
            lat_vc    <= pkt_vc;
            lat_dt    <= pkt_dt;
            lat_wc    <= pkt_wc;
            pkt_ready <= 1'b0;
            hs_req    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            state     <= S_PREP;
          end
        end
        S_PREP: begin
          if (cnt == 16'(PREP_CYCLES - 1)) begin
            lane_valid <= 2'b11;
            lane_data  <= 16'hB8B8;
            pos        <= '0;
            crc        <= 16'hFFFF;
            trail_cnt  <= '0;
            state      <= S_SYNC;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_EXIT: begin
          if (cnt == 16'(EXIT_CYCLES - 1)) begin
            busy      <= 1'b0;
            pkt_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          for (int l = 0; l < 2; l++) begin
            if (lane_live[l]) begin
              lane_valid[l]      <= 1'b1;
              lane_data[8*l +: 8] <= lane_byte[l];
              last_b7[l]         <= lane_byte[l][7];
            end else if (trail_live[l]) begin
              lane_valid[l]      <= 1'b1;
              lane_data[8*l +: 8] <= {8{~last_b7[l]}};
              trail_cnt[l]       <= trail_cnt[l] + 3'd1;
            end else begin
              lane_valid[l]      <= 1'b0;
              lane_data[8*l +: 8] <= 8'h00;
            end
          end
          if (in_pay_cur) begin
            crc      <= last_odd ? crc_lo : crc_hi;
            underrun <= !pl_valid;
          end
          pos      <= pos_nx;
          pl_ready <= in_pay_nx;
          if (|lane_live) begin
            state <= (pos < 17'd4) ? S_HDR : (in_pay_cur ? S_PAY : S_CRC);
          end else if (|trail_live) begin
            state <= S_TRAIL;
          end else begin
            hs_req <= 1'b0;
            cnt    <= '0;
            state  <= S_EXIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_tx.sv
// tb/tb_dsi_packet_tx.sv - directed self-checking bench for dsi_packet_tx
module tb_dsi_packet_tx;

  localparam int PREP  = 8;
  localparam int TRAIL = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        pkt_start = 1'b0;
  logic        pkt_ready;
  logic        pkt_long = 1'b0;
  logic [1:0]  pkt_vc = '0;
  logic [5:0]  pkt_dt = '0;
  logic [15:0] pkt_wc = '0;
  logic [15:0] pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic        hs_req;
  logic [1:0]  lane_valid;
  logic [15:0] lane_data;
  logic        busy;
  logic        underrun;

  dsi_packet_tx #(.PREP_CYCLES(PREP), .TRAIL_BYTES(TRAIL), .EXIT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pkt_start(pkt_start), .pkt_ready(pkt_ready),
    .pkt_long(pkt_long), .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .hs_req(hs_req),
    .lane_valid(lane_valid), .lane_data(lane_data), .busy(busy), .underrun(underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  logic [7:0]  stream [$];
  logic [7:0]  exp0 [$];
  logic [7:0]  exp1 [$];
  logic [7:0]  got0 [$];
  logic [7:0]  got1 [$];
  logic [15:0] pay_mem [16];
  int hs_cycles, rdy_cycles, urun_pulses, zero_viol, ready_viol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int first, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, stream[first + i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // split the packet byte stream round-robin, add sync and trail
  task automatic build_exp();
    logic [7:0] last;
`ifdef DSI_TX_EOTP_EN
    stream.push_back(8'h08); stream.push_back(8'h0F);
    stream.push_back(8'h0F); stream.push_back(8'h01);
`endif
    exp0.delete(); exp1.delete();
    exp0.push_back(8'hB8); exp1.push_back(8'hB8);
    for (int k = 0; k < stream.size(); k++) begin
      if (k % 2 == 0) exp0.push_back(stream[k]);
      else            exp1.push_back(stream[k]);
    end
    last = exp0[exp0.size() - 1];
    for (int t = 0; t < TRAIL; t++) exp0.push_back(last[7] ? 8'h00 : 8'hFF);
    last = exp1[exp1.size() - 1];
    for (int t = 0; t < TRAIL; t++) exp1.push_back(last[7] ? 8'h00 : 8'hFF);
  endtask

  task automatic cmp_lanes(input string tag);
    chk({tag, "_len0"}, got0.size(), exp0.size());
    chk({tag, "_len1"}, got1.size(), exp1.size());
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk($sformatf("%s_l0_%0d", tag, i), got0[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk($sformatf("%s_l1_%0d", tag, i), got1[i], exp1[i]);
    chk({tag, "_hs_cycles"}, hs_cycles, PREP + 1 + (stream.size() + 1) / 2 + TRAIL);
    chk({tag, "_idle_lane_zero"}, zero_viol, 0);
    chk({tag, "_ready_while_busy"}, ready_viol, 0);
  endtask

  task automatic run_pkt(input logic lng, input logic [5:0] dt, input logic [15:0] wc,
                         input int bad_beat, input bit poke);
    int beat;
    beat = 0;
    got0.delete(); got1.delete();
    hs_cycles = 0; rdy_cycles = 0; urun_pulses = 0; zero_viol = 0; ready_viol = 0;
    for (int i = 0; i < 50 && !pkt_ready; i++) @(negedge sys_clk);
    chk("ready_before_start", pkt_ready, 1'b1);
    pkt_long = lng; pkt_vc = 2'b00; pkt_dt = dt; pkt_wc = wc; pkt_start = 1'b1;
    @(negedge sys_clk);
    pkt_start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge sys_clk);
      if (!busy) break;
      pkt_start = 1'b0;
      if (poke && cyc == 3) begin
        pkt_start = 1'b1;
        pkt_dt    = 6'h3F;
      end
      if (hs_req) hs_cycles++;
      if (pkt_ready) ready_viol++;
      if (lane_valid[0]) got0.push_back(lane_data[7:0]);
      else if (lane_data[7:0] != 8'h00) zero_viol++;
      if (lane_valid[1]) got1.push_back(lane_data[15:8]);
      else if (lane_data[15:8] != 8'h00) zero_viol++;
      if (underrun) urun_pulses++;
      if (pl_ready) begin
        rdy_cycles++;
        pl_data  = pay_mem[beat];
        pl_valid = (beat != bad_beat);
        beat++;
      end else begin
        pl_data  = 16'h0000;
        pl_valid = 1'b0;
      end
    end
    pkt_start = 1'b0;
    chk("pkt_done_in_budget", busy, 1'b0);
  endtask

  initial begin
    logic [15:0] c;
    // reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_pkt_ready", pkt_ready, 1'b0);
    chk("rst_outputs", {pl_ready, hs_req, lane_valid, lane_data, busy, underrun}, '0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("post_rst_ready", pkt_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // short packet, with a stray pkt_start mid-packet that must be ignored
    stream = '{8'h05, 8'h11, 8'h00, 8'h36};
    build_exp();
    run_pkt(1'b0, 6'h05, 16'h0011, -1, 1'b1);
    cmp_lanes("short");
    chk("short_no_pl_ready", rdy_cycles, 0);

    // long packet with zero-length payload
    stream = '{8'h39, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
    build_exp();
    run_pkt(1'b1, 6'h39, 16'h0000, -1, 1'b0);
    cmp_lanes("wc0");
    chk("wc0_no_pl_ready", rdy_cycles, 0);

    // long packet, odd wc=9, "123456789"
    pay_mem[0] = 16'h3231; pay_mem[1] = 16'h3433; pay_mem[2] = 16'h3635;
    pay_mem[3] = 16'h3837; pay_mem[4] = 16'h0039;
    stream = '{8'h39, 8'h09, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
               8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
    build_exp();
    run_pkt(1'b1, 6'h39, 16'h0009, -1, 1'b0);
    cmp_lanes("wc9");
    chk("wc9_beats", rdy_cycles, 5);
    chk("wc9_underrun", urun_pulses, 0);

    // wc=4 with the second beat invalid: zeros substituted and CRC'd
    pay_mem[0] = 16'h2211; pay_mem[1] = 16'h4433;
    stream = '{8'h39, 8'h04, 8'h00, 8'h2C, 8'h11, 8'h22, 8'h00, 8'h00};
    c = crc_model(4, 4);
    stream.push_back(c[7:0]);
    stream.push_back(c[15:8]);
    build_exp();
    run_pkt(1'b1, 6'h39, 16'h0004, 1, 1'b0);
    cmp_lanes("underrun");
    chk("underrun_beats", rdy_cycles, 2);
    chk("underrun_pulses", urun_pulses, 1);

    // reset during payload
    pay_mem[0] = 16'h3231;
    pkt_long = 1'b1; pkt_dt = 6'h39; pkt_wc = 16'h0009; pkt_start = 1'b1;
    @(negedge sys_clk);
    pkt_start = 1'b0;
    for (int i = 0; i < 40 && !pl_ready; i++) @(negedge sys_clk);
    chk("rst_reach_pay", pl_ready, 1'b1);
    pl_data = pay_mem[0]; pl_valid = 1'b1;
    @(negedge sys_clk);
    pl_valid = 1'b0;
    chk("pre_rst_hs", hs_req, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {pkt_ready, pl_ready, hs_req, lane_valid, lane_data, busy, underrun}, '0);
    @(posedge sys_clk); #1;
    chk("rst_mid_held", {pkt_ready, pl_ready, hs_req, lane_valid, lane_data, busy, underrun}, '0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst_mid_ready", pkt_ready, 1'b1);
    stream = '{8'h05, 8'h11, 8'h00, 8'h36};
    build_exp();
    run_pkt(1'b0, 6'h05, 16'h0011, -1, 1'b0);
    cmp_lanes("after_rst");

`ifdef DSI_TX_EOTP_EN
    // EoTp appended to a short packet: 05 29 00 1C 08 0F 0F 01
    stream = '{8'h05, 8'h29, 8'h00, 8'h1C};
    build_exp();
    run_pkt(1'b0, 6'h05, 16'h0029, -1, 1'b0);
    cmp_lanes("eotp");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
